tmr1_peripheral: RTL



---
 rtl/tmr1_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 47 ++++
 rtl/tmr1_peripheral.sv | 115 +++++++++++
 3 files changed

// File: rtl/tmr1_pkg.sv
// Shared definitions for the Timer1 peripheral: default register addresses,
// T1CON bit positions and the prescaler mask helper.
package tmr1_pkg;

    localparam logic [8:0] TMR1L_ADDR_DFLT = 9'h00E;
    localparam logic [8:0] TMR1H_ADDR_DFLT = 9'h00F;
    localparam logic [8:0] T1CON_ADDR_DFLT = 9'h010;

    localparam int T1CKPS_HI = 5;
    localparam int T1CKPS_LO = 4;
    localparam int T1OSCEN   = 3;
    localparam int T1SYNC_N  = 2;
    localparam int TMR1CS    = 1;
    localparam int TMR1ON    = 0;

    // Low psc bits that must all be set before a source tick passes through.
    function automatic logic [2:0] prescale_mask(input logic [1:0] ckps);
        logic [2:0] mask;
        case (ckps)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Optional N-flop synchroniser followed by a one-flop rising-edge detector.
// Latency: SYNC_STAGES clk cycles to the pulse; the pulse itself is combinational off the last flop.
// Backpressure: none, free-running.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic level;
    logic edge_q;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign level = sync_q[SYNC_STAGES-1];
        end else begin : g_direct
            assign level = din;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= level;
        end
    end

    assign rise = level & ~edge_q;

endmodule

// File: rtl/tmr1_peripheral.sv
// PIC16-style Timer1: 16-bit counter with 1/2/4/8 prescaler, clkout or synchronised T1CKI source.
// Latency: clkout edge to count 1 clk, t1cki edge to count 3-4 clk; register write visible next cycle.
// Backpressure: none; writes are single-cycle strobes and reads are combinational.
module tmr1_peripheral
    import tmr1_pkg::*;
#(
    parameter logic [8:0] TMR1L_ADDR = TMR1L_ADDR_DFLT,
    parameter logic [8:0] TMR1H_ADDR = TMR1H_ADDR_DFLT,
    parameter logic [8:0] T1CON_ADDR = T1CON_ADDR_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkout,
    input  logic       t1cki,
    input  logic [8:0] addr,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic [7:0] data_out,
    output logic       tmr1if_set_en
);

    logic [7:0]  tmr1l;
    logic [7:0]  tmr1h;
    logic [5:0]  t1con;
    logic [2:0]  psc;
    logic [2:0]  psc_mask;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        int_tick;
    logic        ext_tick;
    logic        src_tick;
    logic        run_tick;
    logic        inc;
    logic        wr_l;
    logic        wr_h;
    logic        wr_c;
    logic        tmr_wr;

    sync_edge_detect #(.SYNC_STAGES(0)) u_clkout_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (clkout),
        .rise (int_tick)
    );

    sync_edge_detect #(.SYNC_STAGES(2)) u_t1cki_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (t1cki),
        .rise (ext_tick)
    );

    assign wr_l   = wr_en && (addr == TMR1L_ADDR);
    assign wr_h   = wr_en && (addr == TMR1H_ADDR);
    assign wr_c   = wr_en && (addr == T1CON_ADDR);
    assign tmr_wr = wr_l | wr_h;

    // Both detectors run regardless of TMR1CS so switching source never fakes an edge.
    assign src_tick = t1con[TMR1CS] ? ext_tick : int_tick;
    assign run_tick = src_tick & t1con[TMR1ON];
    assign psc_mask = prescale_mask(t1con[T1CKPS_HI:T1CKPS_LO]);
    assign inc      = run_tick && ((psc & psc_mask) == psc_mask) && !tmr_wr;

    assign cnt     = {tmr1h, tmr1l};
    assign cnt_nxt = cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= 3'd0;
        end else if (tmr_wr) begin
            psc <= 3'd0;
        end else if (run_tick) begin
            psc <= psc + 3'd1;
        end
    end

    // A counter byte write beats a coincident increment, including a would-be overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr1l         <= 8'h00;
            tmr1h         <= 8'h00;
            tmr1if_set_en <= 1'b0;
        end else begin
            tmr1if_set_en <= inc && (cnt == 16'hFFFF);
            if (wr_l) begin
                tmr1l <= data_in;
            end else if (wr_h) begin
                tmr1h <= data_in;
            end else if (inc) begin
                tmr1l <= cnt_nxt[7:0];
                tmr1h <= cnt_nxt[15:8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1con <= 6'h00;
        end else if (wr_c) begin
            t1con <= data_in[5:0];
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (addr == TMR1L_ADDR) begin
            data_out = tmr1l;
        end else if (addr == TMR1H_ADDR) begin
            data_out = tmr1h;
        end else if (addr == T1CON_ADDR) begin
            data_out = {2'b00, t1con};
        end
    end

endmodule
